// File: rtl/sram_port_arbiter.sv
// Two-master Avalon-MM arbiter for a single-port SRAM with a fixed-latency read tag pipeline.
// Build option: define SRAM_ARB_M0_PRIORITY_EN to give m0 fixed priority instead of round-robin.
module sram_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic [DATA_W-1:0]     s_readdata
);

    logic req_0;
    logic req_1;
    logic gnt_0;
    logic gnt_1;

    logic [READ_LATENCY-1:0] tag_vld_q;
    logic [READ_LATENCY-1:0] tag_vld_d;
    logic [READ_LATENCY-1:0] tag_id_q;
    logic [READ_LATENCY-1:0] tag_id_d;

    assign req_0 = m0_read | m0_write;
    assign req_1 = m1_read | m1_write;

`ifdef SRAM_ARB_M0_PRIORITY_EN
    always_comb begin
        gnt_0 = reset_n & req_0;
        gnt_1 = reset_n & req_1 & ~req_0;
    end
`else
    logic last_gnt_q;
    logic last_gnt_d;

    // No grant while reset is held, so requesters see waitrequest during reset.
    always_comb begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        if (reset_n) begin
            if (req_0 && req_1) begin
                gnt_0 = last_gnt_q;
                gnt_1 = ~last_gnt_q;
            end else begin
                gnt_0 = req_0;
                gnt_1 = req_1;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt_0) begin
            last_gnt_d = 1'b0;
        end else if (gnt_1) begin
            last_gnt_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    assign m0_waitrequest = req_0 & ~gnt_0;
    assign m1_waitrequest = req_1 & ~gnt_1;

    // A simultaneous read+write from one master issues only the write.
    always_comb begin
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_writedata  = '0;
        s_byteenable = '0;
        if (gnt_0) begin
            s_address    = m0_address;
            s_read       = m0_read & ~m0_write;
            s_write      = m0_write;
            s_writedata  = m0_writedata;
            s_byteenable = m0_byteenable;
        end else if (gnt_1) begin
            s_address    = m1_address;
            s_read       = m1_read & ~m1_write;
            s_write      = m1_write;
            s_writedata  = m1_writedata;
            s_byteenable = m1_byteenable;
        end
    end

    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = s_read;
        tag_id_d[0]  = gnt_1;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    assign m0_readdatavalid = tag_vld_q[READ_LATENCY-1] & ~tag_id_q[READ_LATENCY-1];
    assign m1_readdatavalid = tag_vld_q[READ_LATENCY-1] &  tag_id_q[READ_LATENCY-1];
    assign m0_readdata      = m0_readdatavalid ? s_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? s_readdata : '0;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single port of the on-chip SRAM between two Avalon-MM masters.
- m0 is the HPS lightweight-bridge side; m1 is an FPGA-fabric requester, such as a button-event logger.
- Grants one transfer per cycle using round-robin arbitration with a registered last-grant pointer.
- Tracks in-flight reads through a READ_LATENCY-deep tag pipeline so each master receives readdatavalid only for its own reads.
- Sits inside the system fabric, between the masters and the RAM's Avalon-MM slave.

Parameters:
- ADDR_W, 10, word address width.
- DATA_W, 32, data width in bits; must be a multiple of 8.
- READ_LATENCY, 2, fixed SRAM read latency in cycles; allowed range 1..4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address  in  ADDR_W  master 0 word address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_byteenable  in  DATA_W/8  master 0 byte lanes
- m0_waitrequest  out  1  high: master 0 request not accepted this cycle
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data valid
- m1_*  same set and meaning as m0_*, for master 1
- s_address  out  ADDR_W  to SRAM
- s_read  out  1  to SRAM
- s_write  out  1  to SRAM
- s_writedata  out  DATA_W  to SRAM
- s_byteenable  out  DATA_W/8  to SRAM
- s_readdata  in  DATA_W  from SRAM, valid READ_LATENCY cycles after s_read

Behaviour:
- Request definition: req_i = mi_read | mi_write. A master holds its request and all signals stable while its waitrequest is high (Avalon rule; not checked).
- Grant:
  - Combinational from req_0, req_1 and the registered pointer last_gnt.
  - Only one requesting: it is granted.
  - Both requesting: the master other than last_gnt is granted.
  - Neither requesting: no grant, and all s_* controls are 0.
- waitrequest:
  - mi_waitrequest = req_i & ~gnt_i.
  - An idle master sees waitrequest 0.
  - A granted transfer completes in the same cycle.
- Pointer update: last_gnt updates on a clk edge only when a grant occurs. It holds otherwise.
- Slave mux:
  - s_address, s_writedata and s_byteenable come from the granted master; they are 0 when there is no grant.
  - s_read = granted read; s_write = granted write.
- Simultaneous read and write from one master: the write wins. The read is dropped and no readdatavalid is produced for it.
- Read tag pipeline:
  - Shift register of READ_LATENCY stages, each holding {valid, id}.
  - Stage 0 loads {s_read, granted id} every cycle.
  - At the final stage, valid with id=i asserts mi_readdatavalid for one cycle.
- Read data: mi_readdata = s_readdata whenever mi_readdatavalid is high; it is 0 otherwise.
- Throughput:
  - Back-to-back reads from alternating masters are accepted every cycle.
  - Per-master ordering is preserved because latency is fixed.
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - last_gnt = 1, so m0 wins the first contention.
  - All tag stages are cleared.
  - readdatavalid outputs and readdata outputs are 0.
  - waitrequest follows the combinational rule and is 1 for any requester while reset is active, because no grant is made during reset.
  - s_read and s_write are 0 during reset.
- Reset mid-operation: in-flight reads are discarded and no readdatavalid is produced after reset.
- Starvation bound: a continuously requesting master waits at most 1 cycle.

Optional Feature:
- Macro: SRAM_ARB_M0_PRIORITY_EN.
- Defined:
  - m0 has fixed priority; on contention m0 is always granted.
  - last_gnt is not implemented.
  - m1 may starve; this is acceptable for HPS-critical accesses.
- Undefined: round-robin as above.

Test Plan:
- Reset release, m0 write addr 0x005 data 0xDEADBEEF be 0xF, no m1 activity:
  - m0_waitrequest=0 in the request cycle.
  - s_write=1, s_address=0x005, s_writedata=0xDEADBEEF.
- m0 read 0x005 with READ_LATENCY=2:
  - s_read high in cycle N.
  - m0_readdatavalid=1 only in cycle N+2, m0_readdata=0xDEADBEEF.
  - m1_readdatavalid stays 0.
- m0 and m1 both read every cycle for 6 cycles after reset:
  - Grants alternate m0,m1,m0,m1…
  - Each master's waitrequest is high in alternate cycles.
  - Each master receives 3 readdatavalid pulses in issue order.
- Same cycle, m0 write 0x010 data 0x11111111 and m1 read 0x010:
  - m0 is granted first; m1 is granted the next cycle.
  - m1 reads 0x11111111.
- Reset asserted one cycle after an m1 read is granted:
  - No m1_readdatavalid ever appears.
  - After release, last_gnt=1 and the first contention goes to m0.
- With SRAM_ARB_M0_PRIORITY_EN, m0 and m1 requesting continuously for 5 cycles:
  - m0 is granted all 5 cycles.
  - m1_waitrequest=1 throughout; m1 is granted in the cycle m0 deasserts.
